// File: rtl/fifo_dbg_pkg.sv
// Shared types and constants for the FIFO read checker.
// FIFO_RD_CHECKER_FLUSH_EN adds the post-burst FLUSH state.
package fifo_dbg_pkg;

    localparam int unsigned DefDataW     = 8;
    localparam int unsigned CntW         = 16;
    localparam logic [CntW-1:0] NoErrIdx = 16'hFFFF;
    localparam int unsigned FlushIdleLen = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
`ifdef FIFO_RD_CHECKER_FLUSH_EN
        StReport,
        StFlush
`else
        StReport
`endif
    } state_e;

endpackage

// File: rtl/fifo_rd_pattern_gen.sv
// Expected-word generator: loads SEED at burst start and steps by one per
// checked word, wrapping modulo 2^DATA_W.
module fifo_rd_pattern_gen
    import fifo_dbg_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned SEED   = 0
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] expected
);

    logic [DATA_W-1:0] expected_q, expected_d;

    always_comb begin
        expected_d = expected_q;
        if (load) begin
            expected_d = DATA_W'(SEED);
        end else if (advance) begin
            expected_d = expected_q + DATA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            expected_q <= DATA_W'(SEED);
        end else begin
            expected_q <= expected_d;
        end
    end

    assign expected = expected_q;

endmodule

// File: rtl/fifo_rd_checker.sv
// Reads a burst from a standard (non-FWFT) FIFO and checks it against an
// incrementing pattern. FIFO_RD_CHECKER_FLUSH_EN enables the post-burst drain.
module fifo_rd_checker
    import fifo_dbg_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned BURST_LEN   = 257,
    parameter int unsigned SEED        = 0,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CntW-1:0]   err_cnt,
    output logic [CntW-1:0]   first_err_idx,
    output logic [CntW-1:0]   extra_cnt
);

    localparam logic [CntW-1:0] BurstLen = CntW'(BURST_LEN);
    localparam logic [31:0]     TimeoutCyc = 32'(TIMEOUT_CYC);

    state_e            state_q, state_d;
    logic [CntW-1:0]   issued_q, issued_d;
    logic [CntW-1:0]   checked_q, checked_d;
    logic [CntW-1:0]   err_cnt_q, err_cnt_d;
    logic [CntW-1:0]   first_err_q, first_err_d;
    logic [CntW-1:0]   extra_q, extra_d;
    logic [31:0]       idle_q, idle_d;
    logic              rd_vld_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
`ifdef FIFO_RD_CHECKER_FLUSH_EN
    logic [4:0]        flush_idle_q, flush_idle_d;
`endif

    logic              rd_en;
    logic              start_acc;
    logic              chk_en;
    logic              mismatch;
    logic [DATA_W-1:0] exp_word;

    assign start_acc = (state_q == StIdle) && start;
    // Words drained in FLUSH also raise rd_vld but are never compared.
    assign chk_en    = rd_vld_q && (checked_q < BurstLen);
    assign mismatch  = chk_en && (fifo_dout != exp_word);

    fifo_rd_pattern_gen #(
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_pattern_gen (
        .clk      (clk),
        .srst     (srst),
        .load     (start_acc),
        .advance  (chk_en),
        .expected (exp_word)
    );

    always_comb begin
        rd_en = 1'b0;
        unique case (state_q)
            StRead:  rd_en = !fifo_empty && (issued_q < BurstLen);
`ifdef FIFO_RD_CHECKER_FLUSH_EN
            StFlush: rd_en = !fifo_empty;
`endif
            default: rd_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        checked_d   = checked_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        extra_d     = extra_q;
        idle_d      = idle_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
`ifdef FIFO_RD_CHECKER_FLUSH_EN
        flush_idle_d = flush_idle_q;
`endif

        if (start_acc) begin
            state_d     = StRead;
            issued_d    = '0;
            checked_d   = '0;
            err_cnt_d   = '0;
            first_err_d = NoErrIdx;
            extra_d     = '0;
            idle_d      = '0;
            pass_d      = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            if (chk_en) begin
                checked_d = checked_q + CntW'(1);
                if (mismatch) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CntW'(1);
                    end
                    if (first_err_q == NoErrIdx) begin
                        first_err_d = checked_q;
                    end
                end
            end

            unique case (state_q)
                StRead: begin
                    if (rd_en) begin
                        issued_d = issued_q + CntW'(1);
                        idle_d   = '0;
                        if (issued_d == BurstLen) begin
                            state_d = StWait;
                        end
                    end else begin
                        idle_d = idle_q + 32'd1;
                        if (idle_d == TimeoutCyc) begin
                            timeout_d = 1'b1;
                            state_d   = StWait;
                        end
                    end
                end
                StWait: begin
                    // checked_d includes the word landing this cycle.
                    if (timeout_q || (checked_d == BurstLen)) begin
                        state_d = StReport;
                        pass_d  = (err_cnt_d == '0) && !timeout_q && (extra_q == '0);
                    end
                end
                StReport: begin
                    state_d = StIdle;
`ifdef FIFO_RD_CHECKER_FLUSH_EN
                    if (!timeout_q) begin
                        state_d      = StFlush;
                        flush_idle_d = '0;
                    end
`endif
                end
`ifdef FIFO_RD_CHECKER_FLUSH_EN
                StFlush: begin
                    if (rd_en) begin
                        flush_idle_d = '0;
                        if (extra_q != '1) begin
                            extra_d = extra_q + CntW'(1);
                        end
                    end else begin
                        flush_idle_d = flush_idle_q + 5'd1;
                        if (flush_idle_d == 5'(FlushIdleLen)) begin
                            state_d = StIdle;
                            pass_d  = (err_cnt_q == '0) && !timeout_q && (extra_q == '0);
                        end
                    end
                end
`endif
                default: ;
            endcase
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StReport);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= StIdle;
            issued_q    <= '0;
            checked_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= NoErrIdx;
            extra_q     <= '0;
            idle_q      <= '0;
            rd_vld_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef FIFO_RD_CHECKER_FLUSH_EN
            flush_idle_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            checked_q   <= checked_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            extra_q     <= extra_d;
            idle_q      <= idle_d;
            rd_vld_q    <= rd_en;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
`ifdef FIFO_RD_CHECKER_FLUSH_EN
            flush_idle_q <= flush_idle_d;
`endif
        end
    end

    assign fifo_rd_en    = rd_en;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;
`ifdef FIFO_RD_CHECKER_FLUSH_EN
    assign extra_cnt     = extra_q;
`else
    assign extra_cnt     = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Scoreboard bench for fifo_rd_checker: directed bursts against a behavioural
// standard-read FIFO; expected reports are checked whenever done pulses.
module tb_fifo_rd_checker;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [15:0] err;
        logic [15:0] first;
        logic [15:0] extra;
    } exp_t;

    logic        clk = 1'b0;
    logic        srst;
    logic        start;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt, first_err_idx, extra_cnt;

    logic [7:0]  mem [0:511];
    int          wr_cnt;
    int          rd_ptr;
    logic        stall;
    logic        fifo_clr;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fifo_rd_checker dut (
        .clk           (clk),
        .srst          (srst),
        .start         (start),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .extra_cnt     (extra_cnt)
    );

    // Standard FIFO: data appears on fifo_dout the cycle after a read.
    assign fifo_empty = stall || (rd_ptr >= wr_cnt);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= 0;
        end else if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                chk("done_pass", {31'd0, pass}, {31'd0, e.pass});
                chk("done_timeout", {31'd0, timeout}, {31'd0, e.timeout});
                chk("done_err_cnt", {16'd0, err_cnt}, {16'd0, e.err});
                chk("done_first_err_idx", {16'd0, first_err_idx}, {16'd0, e.first});
                chk("done_extra_cnt", {16'd0, extra_cnt}, {16'd0, e.extra});
            end
        end
    end

    task automatic push_exp(input logic p, input logic t, input logic [15:0] e,
                            input logic [15:0] f, input logic [15:0] x);
        exp_t v;
        v.pass = p; v.timeout = t; v.err = e; v.first = f; v.extra = x;
        sb.push_back(v);
    endtask

    task automatic load_fifo(input int n);
        @(negedge clk);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        for (int i = 0; i < n; i++) mem[i] = 8'(i);
        wr_cnt = n;
    endtask

    // Pulse start, then run until busy drops; optional stall toggling and a
    // stray start pulse at cycle start_at.
    task automatic run_burst(input int budget, input bit toggle, input int start_at);
        bit finished = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            stall = toggle ? (((i / 3) % 2) == 1) : 1'b0;
            start = (i == start_at);
            @(negedge clk);
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL burst_budget actual=busy required=idle");
        end
    endtask

    initial begin
        srst     = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        fifo_clr = 1'b1;
        wr_cnt   = 0;
        repeat (3) @(negedge clk);
        fifo_clr = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("rst_first_err_idx", {16'd0, first_err_idx}, 32'h0000_FFFF);
        chk("rst_extra_cnt", {16'd0, extra_cnt}, 32'd0);
        srst = 1'b0;

        // Clean 257-word burst with 8-bit wrap.
        load_fifo(257);
        push_exp(1'b1, 1'b0, 16'd0, 16'hFFFF, 16'd0);
        run_burst(600, 1'b0, -1);
        chk("clean_pass_after", {31'd0, pass}, 32'd1);

        // Word 10 corrupted.
        load_fifo(257);
        mem[10] = 8'hAA;
        push_exp(1'b0, 1'b0, 16'd1, 16'd10, 16'd0);
        run_burst(600, 1'b0, -1);

        // Short supply: timeout after 1024 idle READ cycles.
        load_fifo(100);
        push_exp(1'b0, 1'b1, 16'd0, 16'hFFFF, 16'd0);
        run_burst(2000, 1'b0, -1);
        chk("timeout_rd_ptr", 32'(rd_ptr), 32'd100);

        // Stalling FIFO plus stray start while busy.
        load_fifo(257);
        push_exp(1'b1, 1'b0, 16'd0, 16'hFFFF, 16'd0);
        run_burst(1200, 1'b1, 20);
        chk("stall_rd_ptr", 32'(rd_ptr), 32'd257);

        // Reset mid-burst at word 50, then a fresh burst.
        load_fifo(257);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && rd_ptr < 50; i++) @(negedge clk);
        chk("abort_reached_word50", {31'd0, rd_ptr >= 50}, 32'd1);
        srst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("abort_first_err_idx", {16'd0, first_err_idx}, 32'h0000_FFFF);
        chk("abort_err_cnt", {16'd0, err_cnt}, 32'd0);
        @(negedge clk);
        srst = 1'b0;
        load_fifo(257);
        push_exp(1'b1, 1'b0, 16'd0, 16'hFFFF, 16'd0);
        run_burst(600, 1'b0, -1);

        // Three words beyond the burst.
        load_fifo(260);
        push_exp(1'b1, 1'b0, 16'd0, 16'hFFFF, 16'd0);
        run_burst(600, 1'b0, -1);
`ifdef FIFO_RD_CHECKER_FLUSH_EN
        chk("extra_words_cnt", {16'd0, extra_cnt}, 32'd3);
        chk("extra_words_pass", {31'd0, pass}, 32'd0);
`else
        chk("extra_words_cnt", {16'd0, extra_cnt}, 32'd0);
        chk("extra_words_pass", {31'd0, pass}, 32'd1);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
